// File: rtl/clk_mon_pkg.sv
// Shared types and default sizing for the clock monitor controller.
// Used by clk_mon_ctrl and clk_mon_period_cnt; CLKMON_RECOVERY_EN is handled in clk_mon_ctrl.
package clk_mon_pkg;

    localparam int CNT_W_DEF         = 8;
    localparam int FAIL_LIMIT_DEF    = 3;
    localparam int RECOVER_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_FAILED  = 2'd3
    } state_e;

    // Width able to hold the larger of the two consecutive-period limits.
    function automatic int tally_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_mon_period_cnt.sv
// Period counter: counts clk cycles between monitored edges, times out at all-ones,
// and registers the measured period with a one-cycle valid strobe.
module clk_mon_period_cnt
    import clk_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             run_i,
    input  logic             edge_i,
    output logic             hit_o,
    output logic [CNT_W-1:0] meas_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;

    // A timeout closes a period exactly like an edge would, so both share one path.
    assign hit_o  = edge_i | (cnt_q == CNT_MAX);
    assign meas_o = cnt_q;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_ONE;
        end else if (run_i) begin
            if (hit_o) begin
                period_d = cnt_q;
                valid_d  = 1'b1;
                cnt_d    = CNT_ONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;

endmodule

// File: rtl/clk_mon_ctrl.sv
// Clock monitor controller: sequencing FSM plus consecutive-violation tracking.
// Define CLKMON_RECOVERY_EN to keep measuring in FAILED and auto-recover clk_sel.
//
// state      | meaning
// IDLE       | not monitoring, counter cleared
// ARM        | waiting for first monitored edge to open a period
// MEASURE    | measuring periods, counting consecutive violations
// FAILED     | fail latched, external clock selected
module clk_mon_ctrl
    import clk_mon_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int FAIL_LIMIT    = FAIL_LIMIT_DEF,
    parameter int RECOVER_LIMIT = RECOVER_LIMIT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic             edge_pulse_i,
    input  logic [CNT_W-1:0] psi_min_i,
    input  logic [CNT_W-1:0] psi_max_i,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             fail_o,
    output logic             clk_sel_o,
    output logic             busy_o
);

    localparam int                 TALLY_W  = tally_width(FAIL_LIMIT, RECOVER_LIMIT);
    localparam logic [TALLY_W-1:0] FAIL_LIM = TALLY_W'(FAIL_LIMIT);

    state_e             state_q, state_d;
    logic [TALLY_W-1:0] viol_q, viol_d, viol_inc;
    logic               fail_q, fail_d;
    logic               clk_sel_q, clk_sel_d;
    logic               cnt_clr, cnt_load, cnt_run;
    logic               hit;
    logic [CNT_W-1:0]   meas;
    logic               in_range;

`ifdef CLKMON_RECOVERY_EN
    localparam logic [TALLY_W-1:0] REC_LIM = TALLY_W'(RECOVER_LIMIT);
    logic [TALLY_W-1:0] rec_q, rec_d, rec_inc;
`endif

    clk_mon_period_cnt #(
        .CNT_W (CNT_W)
    ) u_period_cnt (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .clr_i          (cnt_clr),
        .load_i         (cnt_load),
        .run_i          (cnt_run),
        .edge_i         (edge_pulse_i),
        .hit_o          (hit),
        .meas_o         (meas),
        .period_o       (period_o),
        .period_valid_o (period_valid_o)
    );

    // Judged on the value being latched so the verdict lands with the strobe.
    assign in_range = (meas >= psi_min_i) && (meas <= psi_max_i);
    assign viol_inc = (viol_q >= FAIL_LIM) ? FAIL_LIM : viol_q + 1'b1;
`ifdef CLKMON_RECOVERY_EN
    assign rec_inc  = (rec_q >= REC_LIM) ? REC_LIM : rec_q + 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        viol_d    = viol_q;
        fail_d    = fail_q;
        clk_sel_d = clk_sel_q;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_run   = 1'b0;
`ifdef CLKMON_RECOVERY_EN
        rec_d     = rec_q;
`endif
        if (clear_i) begin
            state_d   = ST_IDLE;
            viol_d    = '0;
            fail_d    = 1'b0;
            clk_sel_d = 1'b0;
            cnt_clr   = 1'b1;
`ifdef CLKMON_RECOVERY_EN
            rec_d     = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (stop_i) begin
                        state_d = ST_IDLE;
                        cnt_clr = 1'b1;
                    end else if (edge_pulse_i) begin
                        state_d  = ST_MEASURE;
                        cnt_load = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (stop_i) begin
                        state_d = ST_IDLE;
                        viol_d  = '0;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_run = 1'b1;
                        if (hit) begin
                            if (in_range) begin
                                viol_d = '0;
                            end else begin
                                viol_d = viol_inc;
                                if (viol_inc == FAIL_LIM) begin
                                    state_d   = ST_FAILED;
                                    fail_d    = 1'b1;
                                    clk_sel_d = 1'b1;
`ifdef CLKMON_RECOVERY_EN
                                    rec_d     = '0;
`endif
                                end
                            end
                        end
                    end
                end
                ST_FAILED: begin
`ifdef CLKMON_RECOVERY_EN
                    // fail stays latched on recovery; only clk_sel is released.
                    cnt_run = 1'b1;
                    if (hit) begin
                        if (in_range) begin
                            viol_d = '0;
                            if (rec_inc == REC_LIM) begin
                                state_d   = ST_MEASURE;
                                clk_sel_d = 1'b0;
                                rec_d     = '0;
                            end else begin
                                rec_d = rec_inc;
                            end
                        end else begin
                            rec_d = '0;
                        end
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            viol_q    <= '0;
            fail_q    <= 1'b0;
            clk_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            viol_q    <= viol_d;
            fail_q    <= fail_d;
            clk_sel_q <= clk_sel_d;
        end
    end

`ifdef CLKMON_RECOVERY_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rec_q <= '0;
        else          rec_q <= rec_d;
    end
`endif

    assign fail_o    = fail_q;
    assign clk_sel_o = clk_sel_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_mon_ctrl.sv
// Scoreboard bench for clk_mon_ctrl: a time-stamp based reference model predicts
// each period strobe and the steady outputs; a monitor compares what the DUT shows.
module tb_clk_mon_ctrl;

    localparam int FL   = 3;
    localparam int RL   = 4;
    localparam int MAXP = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, edge_p = 1'b0;
    logic [7:0] psi_min = 8'd2, psi_max = 8'd3;
    logic [7:0] period;
    logic       period_valid, fail, clk_sel, busy;

    int nxt_min = 2, nxt_max = 3;
    int checks = 0, errors = 0;

    typedef struct {
        int period;
        bit fail;
        bit sel;
    } exp_t;
    exp_t sb_q[$];

    typedef enum {M_IDLE, M_ARMED, M_MEAS, M_FAILED} mmode_e;
    mmode_e m_mode = M_IDLE;
    int m_now = 0, m_ref = 0, m_bad = 0, m_good = 0, m_period = 0;
    bit m_fail = 0, m_sel = 0, m_strobe = 0;

    always #5 clk = ~clk;

    clk_mon_ctrl #(
        .CNT_W         (8),
        .FAIL_LIMIT    (FL),
        .RECOVER_LIMIT (RL)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .stop_i         (stop),
        .clear_i        (clear),
        .edge_pulse_i   (edge_p),
        .psi_min_i      (psi_min),
        .psi_max_i      (psi_max),
        .period_o       (period),
        .period_valid_o (period_valid),
        .fail_o         (fail),
        .clk_sel_o      (clk_sel),
        .busy_o         (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A period is the number of cycles since the previous reference point; it closes on an
    // edge or when it reaches the all-ones limit.
    task automatic measure(input bit e);
        int el;
        el = m_now - m_ref;
        if (e || el >= MAXP) begin
            m_strobe = 1;
            m_period = el;
            m_ref    = m_now;
            if (el >= int'(psi_min) && el <= int'(psi_max)) begin
                m_bad = 0;
                if (m_mode == M_FAILED) begin
                    m_good++;
                    if (m_good == RL) begin
                        m_mode = M_MEAS;
                        m_sel  = 0;
                        m_good = 0;
                    end
                end
            end else begin
                m_good = 0;
                if (m_bad < FL) m_bad++;
                if (m_mode == M_MEAS && m_bad == FL) begin
                    m_mode = M_FAILED;
                    m_fail = 1;
                    m_sel  = 1;
                end
            end
            sb_q.push_back('{m_period, m_fail, m_sel});
        end
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit e);
        m_now++;
        m_strobe = 0;
        if (c) begin
            m_mode = M_IDLE;
            m_fail = 0;
            m_sel  = 0;
            m_bad  = 0;
            m_good = 0;
        end else begin
            case (m_mode)
                M_IDLE:   if (s) m_mode = M_ARMED;
                M_ARMED: begin
                    if (p) m_mode = M_IDLE;
                    else if (e) begin
                        m_mode = M_MEAS;
                        m_ref  = m_now;
                    end
                end
                M_MEAS: begin
                    if (p) begin
                        m_mode = M_IDLE;
                        m_bad  = 0;
                    end else measure(e);
                end
                M_FAILED: begin
`ifdef CLKMON_RECOVERY_EN
                    measure(e);
`endif
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic tick(input bit s, input bit p, input bit c, input bit e);
        @(negedge clk);
        psi_min = 8'(nxt_min);
        psi_max = 8'(nxt_max);
        start   = s;
        stop    = p;
        clear   = c;
        edge_p  = e;
        model_step(s, p, c, e);
    endtask

    task automatic run_edges(input int gap, input int n);
        for (int k = 0; k < n; k++) begin
            repeat (gap - 1) tick(0, 0, 0, 0);
            tick(0, 0, 0, 1);
        end
    endtask

    task automatic set_lim(input int lo, input int hi);
        nxt_min = lo;
        nxt_max = hi;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 0; stop = 0; clear = 0; edge_p = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_period", period, 0);
        chk("rst_valid", period_valid, 0);
        chk("rst_fail", fail, 0);
        chk("rst_clk_sel", clk_sel, 0);
        chk("rst_busy", busy, 0);
        m_mode = M_IDLE; m_fail = 0; m_sel = 0; m_period = 0;
        m_strobe = 0; m_bad = 0; m_good = 0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: samples just after each rising edge, once the model holds post-edge state.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            chk("valid", period_valid, m_strobe);
            if (period_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", period_valid, 0);
                end else begin
                    x = sb_q.pop_front();
                    chk("sb_period", period, x.period);
                    chk("sb_fail", fail, x.fail);
                    chk("sb_clk_sel", clk_sel, x.sel);
                end
            end
            chk("busy", busy, (m_mode != M_IDLE));
            chk("fail", fail, m_fail);
            chk("clk_sel", clk_sel, m_sel);
            chk("period", period, m_period);
        end
    end

    initial begin
        bit s, p, c, e;
        int gap;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Nominal 3-cycle periods.
        set_lim(2, 3);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        run_edges(3, 4);
        // Three long periods declare failure.
        run_edges(6, 3);
        run_edges(3, 2);
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);

        // Edges disappear: timeouts every 255 cycles.
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        repeat (3 * MAXP + 3) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);

        // Good period in the middle resets the violation streak; clear beats start.
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        run_edges(6, 2);
        run_edges(3, 1);
        run_edges(6, 2);
        tick(1, 0, 1, 0);
        tick(0, 0, 0, 0);

        // Edge exactly at the counter maximum; inclusive limit boundaries.
        set_lim(250, 255);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        run_edges(255, 1);
        set_lim(4, 6);
        run_edges(4, 1);
        run_edges(6, 1);
        run_edges(5, 1);
        run_edges(3, 1);
        run_edges(7, 1);
        run_edges(4, 1);

        // Stop holds period; start while busy ignored; stop in ARM.
        set_lim(2, 3);
        run_edges(3, 2);
        tick(0, 1, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 1);

        // Async reset mid-measurement, then inverted limits.
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        run_edges(3, 2);
        repeat (4) tick(0, 0, 0, 0);
        do_reset();
        set_lim(10, 5);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        run_edges(7, 3);
        run_edges(7, 1);
        tick(0, 0, 1, 0);

        // Failure followed by good periods (recovery depends on build).
        set_lim(2, 3);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        run_edges(6, 3);
        run_edges(3, 4);
        tick(0, 1, 0, 0);
        run_edges(3, 2);
        run_edges(6, 3);
        tick(0, 0, 1, 0);

        // Randomized traffic.
        gap = 3;
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) set_lim(int'($urandom_range(1, 8)), int'($urandom_range(1, 10)));
            gap--;
            e = (gap == 0);
            if (e) gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(256, 300))
                                                    : int'($urandom_range(1, 10));
            s = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 299) == 0);
            tick(s, p, c, e);
        end
        tick(0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("sb_leftover", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
